// File: rtl/pb_event_pkg.sv
// Shared types for the push-button gesture classifier: FSM states, event codes
// and the timer sizing helper.
package pb_event_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        GAP    = 3'd2,
        PRESS2 = 3'd3,
        LONG   = 3'd4
    } state_t;

    // Compact event code for a downstream event FIFO.
    typedef enum logic [2:0] {
        EV_NONE   = 3'd0,
        EV_SHORT  = 3'd1,
        EV_LONG   = 3'd2,
        EV_REPEAT = 3'd3,
        EV_DOUBLE = 3'd4
    } ev_code_t;

    // Bits needed to hold the largest of the three cycle limits.
    function automatic int timer_width(input int long_cycles,
                                       input int gap_cycles,
                                       input int repeat_cycles);
        int m;
        m = long_cycles;
        if (gap_cycles > m)    m = gap_cycles;
        if (repeat_cycles > m) m = repeat_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pb_event_classifier.sv
// Classifies debounced press/release pulses into short, long, repeat and double events.
// Latency: events decided in cycle N appear registered in cycle N+1 for one cycle.
// Backpressure: none; pulses are fire-and-forget, the consumer must sample every cycle.
module pb_event_classifier
    import pb_event_pkg::*;
#(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int GAP_CYCLES    = 25_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic pressed_pulse,
    input  logic released_pulse,
    output logic short_o,
    output logic long_o,
    output logic repeat_o,
    output logic double_o,
    output logic hold_o
);

    localparam int TW = timer_width(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES);

    localparam logic [TW-1:0] LONG_LIM   = TW'(LONG_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LIM    = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] REPEAT_LIM = TW'(REPEAT_CYCLES - 1);

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_nxt;
    logic            short_nxt;
    logic            long_nxt;
    logic            repeat_nxt;
    logic            double_nxt;
    logic            hold_nxt;
    logic            press_eff;

    // A release in the same cycle as a press always wins; the press is dropped.
    assign press_eff = pressed_pulse & ~released_pulse;

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer + 1'b1;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;
        double_nxt = 1'b0;

        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (press_eff) begin
                    state_nxt = PRESS1;
                end
            end
            PRESS1: begin
                if (released_pulse) begin
                    state_nxt = GAP;
                end else if (timer == LONG_LIM) begin
                    state_nxt = LONG;
                    long_nxt  = 1'b1;
                end
            end
            GAP: begin
                if (press_eff) begin
                    state_nxt = PRESS2;
                end else if (timer == GAP_LIM) begin
                    state_nxt = IDLE;
                    short_nxt = 1'b1;
                end
            end
            PRESS2: begin
                // Holding the second press long still reports the first click.
                if (released_pulse) begin
                    state_nxt  = IDLE;
                    double_nxt = 1'b1;
                end else if (timer == LONG_LIM) begin
                    state_nxt = LONG;
                    short_nxt = 1'b1;
                    long_nxt  = 1'b1;
                end
            end
            LONG: begin
                if (released_pulse) begin
                    state_nxt = IDLE;
                end else if (timer == REPEAT_LIM) begin
                    repeat_nxt = 1'b1;
                    timer_nxt  = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase

        if (state_nxt != state) begin
            timer_nxt = '0;
        end

        hold_nxt = (state_nxt == LONG);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            timer    <= '0;
            short_o  <= 1'b0;
            long_o   <= 1'b0;
            repeat_o <= 1'b0;
            double_o <= 1'b0;
            hold_o   <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            short_o  <= short_nxt;
            long_o   <= long_nxt;
            repeat_o <= repeat_nxt;
            double_o <= double_nxt;
            hold_o   <= hold_nxt;
        end
    end

endmodule
